// File: rtl/sound_ch2_ctrl.sv
// Channel-2 control: NR21-NR24 register bank, trigger decode, 512 Hz frame
// sequencer strobes, 64-step length counter and channel-active status.
module sound_ch2_ctrl (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iMasterEn,
  input  logic       iTick512,
  input  logic       iWe,
  input  logic [1:0] iAddr,
  input  logic [7:0] iData,
  output logic [7:0] oNR21,
  output logic [7:0] oNR22,
  output logic [7:0] oNR23,
  output logic [7:0] oNR24,
  output logic       oTrigger,
  output logic       oLenTick,
  output logic       oEnvTick,
  output logic       oActive,
  output logic [6:0] oLenCount
);

  localparam logic [1:0] ADDR_NR21 = 2'd0;
  localparam logic [1:0] ADDR_NR22 = 2'd1;
  localparam logic [1:0] ADDR_NR23 = 2'd2;
  localparam logic [1:0] ADDR_NR24 = 2'd3;
  localparam logic [6:0] LEN_FULL  = 7'd64;

  logic [2:0] step_q, step_d;
  logic [7:0] nr21_q, nr21_d;
  logic [7:0] nr22_q, nr22_d;
  logic [7:0] nr23_q, nr23_d;
  logic [7:0] nr24_q, nr24_d;
  logic       trig_q, trig_d;
  logic       len_tick_q, len_tick_d;
  logic       env_tick_q, env_tick_d;
  logic       active_q, active_d;
  logic [6:0] len_q, len_d;
  logic       wr_len, wr_trig;

  assign wr_len  = iWe && (iAddr == ADDR_NR21);
  assign wr_trig = iWe && (iAddr == ADDR_NR24) && iData[7];

  always_comb begin
    step_d     = step_q;
    nr21_d     = nr21_q;
    nr22_d     = nr22_q;
    nr23_d     = nr23_q;
    nr24_d     = nr24_q;
    trig_d     = 1'b0;
    len_tick_d = 1'b0;
    env_tick_d = 1'b0;
    active_d   = active_q;
    len_d      = len_q;

    if (!iMasterEn) begin
      step_d   = 3'd0;
      nr21_d   = 8'd0;
      nr22_d   = 8'd0;
      nr23_d   = 8'd0;
      nr24_d   = 8'd0;
      active_d = 1'b0;
      len_d    = 7'd0;
    end else begin
      if (iTick512) begin
        len_tick_d = ~step_q[0];
        env_tick_d = (step_q == 3'd7);
        step_d     = step_q + 3'd1;
      end

      // A length load or trigger in the same cycle suppresses the decrement.
      if (len_tick_q && nr24_q[6] && (len_q != 7'd0) && !wr_len && !wr_trig) begin
        len_d = len_q - 7'd1;
        if (len_q == 7'd1) active_d = 1'b0;
      end

      if (iWe) begin
        case (iAddr)
          ADDR_NR21: begin
            nr21_d = iData;
            len_d  = LEN_FULL - {1'b0, iData[5:0]};
          end
          ADDR_NR22: begin
            nr22_d = iData;
            if (iData[7:3] == 5'd0) active_d = 1'b0;
          end
          ADDR_NR23: nr23_d = iData;
          ADDR_NR24: begin
            nr24_d = {1'b0, iData[6:0]};
            if (iData[7]) begin
              trig_d   = 1'b1;
              active_d = (nr22_q[7:3] != 5'd0);
              if (len_q == 7'd0) len_d = LEN_FULL;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      step_q     <= 3'd0;
      nr21_q     <= 8'd0;
      nr22_q     <= 8'd0;
      nr23_q     <= 8'd0;
      nr24_q     <= 8'd0;
      trig_q     <= 1'b0;
      len_tick_q <= 1'b0;
      env_tick_q <= 1'b0;
      active_q   <= 1'b0;
      len_q      <= 7'd0;
    end else begin
      step_q     <= step_d;
      nr21_q     <= nr21_d;
      nr22_q     <= nr22_d;
      nr23_q     <= nr23_d;
      nr24_q     <= nr24_d;
      trig_q     <= trig_d;
      len_tick_q <= len_tick_d;
      env_tick_q <= env_tick_d;
      active_q   <= active_d;
      len_q      <= len_d;
    end
  end

  assign oNR21     = nr21_q;
  assign oNR22     = nr22_q;
  assign oNR23     = nr23_q;
  assign oNR24     = nr24_q;
  assign oTrigger  = trig_q;
  assign oLenTick  = len_tick_q;
  assign oEnvTick  = env_tick_q;
  assign oActive   = active_q;
  assign oLenCount = len_q;

endmodule

// File: tb/tb_sound_ch2_ctrl.sv
// Bench for sound_ch2_ctrl: per-feature tasks with a strobe scoreboard queue
// fed from a small frame-sequencer step model.
module tb_sound_ch2_ctrl;

  logic       iClock = 1'b0;
  logic       iReset = 1'b1;
  logic       iMasterEn = 1'b0;
  logic       iTick512 = 1'b0;
  logic       iWe = 1'b0;
  logic [1:0] iAddr = 2'd0;
  logic [7:0] iData = 8'd0;
  logic [7:0] oNR21, oNR22, oNR23, oNR24;
  logic       oTrigger, oLenTick, oEnvTick, oActive;
  logic [6:0] oLenCount;

  sound_ch2_ctrl dut (
    .iClock(iClock), .iReset(iReset), .iMasterEn(iMasterEn), .iTick512(iTick512),
    .iWe(iWe), .iAddr(iAddr), .iData(iData),
    .oNR21(oNR21), .oNR22(oNR22), .oNR23(oNR23), .oNR24(oNR24),
    .oTrigger(oTrigger), .oLenTick(oLenTick), .oEnvTick(oEnvTick),
    .oActive(oActive), .oLenCount(oLenCount)
  );

  always #5 iClock = ~iClock;

  typedef struct packed {
    logic lt;
    logic et;
  } strobe_t;

  strobe_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int model_step = 0;
  int n_lt = 0;
  int n_et = 0;
  logic last_et;

  task automatic cyc();
    @(posedge iClock);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    iWe = 1'b1; iAddr = a; iData = d;
    cyc();
    iWe = 1'b0;
  endtask

  task automatic do_reset();
    iReset = 1'b1;
    cyc();
    iReset = 1'b0;
    model_step = 0;
    exp_q.delete();
  endtask

  // One iTick512 pulse: expected strobes queued at drive time, popped when visible.
  task automatic tick();
    strobe_t e;
    strobe_t got;
    e.lt = iMasterEn && (model_step % 2 == 0);
    e.et = iMasterEn && (model_step == 7);
    if (iMasterEn) model_step = (model_step + 1) % 8;
    exp_q.push_back(e);
    iTick512 = 1'b1;
    cyc();
    iTick512 = 1'b0;
    e = exp_q.pop_front();
    got.lt = oLenTick;
    got.et = oEnvTick;
    if (oLenTick === 1'b1) n_lt++;
    if (oEnvTick === 1'b1) n_et++;
    last_et = oEnvTick;
    checks++;
    if (got !== e)
      $display("FAIL strobe step: lt/et got %b%b expected %b%b", got.lt, got.et, e.lt, e.et);
    cyc();
    checks++;
    if ({oLenTick, oEnvTick} !== 2'b00)
      $display("FAIL strobe_width: lt/et got %b%b expected 00", oLenTick, oEnvTick);
    if ({oLenTick, oEnvTick} !== 2'b00) errors++;
    if (got !== e) errors++;
  endtask

  task automatic test_reset();
    checks++;
    if ({oNR21, oNR22, oNR23, oNR24, oTrigger, oLenTick, oEnvTick, oActive, oLenCount} !== 43'd0) begin
      errors++;
      $display("FAIL reset_initial: outputs got %0h expected 0",
               {oNR21, oNR22, oNR23, oNR24, oTrigger, oLenTick, oEnvTick, oActive, oLenCount});
    end
    iMasterEn = 1'b1;
    do_reset();
    wr(2'd0, 8'h20);
    wr(2'd1, 8'hF0);
    wr(2'd3, 8'hC0);
    tick();
    tick();
    iTick512 = 1'b1;
    cyc();
    iTick512 = 1'b0;
    checks++;
    if (oLenTick !== 1'b1) begin
      errors++;
      $display("FAIL reset_pending_strobe: oLenTick got %b expected 1", oLenTick);
    end
    #2 iReset = 1'b1;
    #1;
    checks++;
    if ({oNR21, oNR22, oNR23, oNR24, oTrigger, oLenTick, oEnvTick, oActive, oLenCount} !== 43'd0) begin
      errors++;
      $display("FAIL reset_async: outputs got %0h expected 0",
               {oNR21, oNR22, oNR23, oNR24, oTrigger, oLenTick, oEnvTick, oActive, oLenCount});
    end
    cyc();
    iReset = 1'b0;
    model_step = 0;
    exp_q.delete();
    tick();
    $display("test_reset done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_frame_seq();
    do_reset();
    n_lt = 0;
    n_et = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++;
      if (last_et !== (i % 8 == 0)) begin
        errors++;
        $display("FAIL env_pulse_pos: pulse %0d oEnvTick got %b expected %b", i, last_et, (i % 8 == 0));
      end
    end
    checks++;
    if (n_lt != 8 || n_et != 2) begin
      errors++;
      $display("FAIL strobe_counts: lt/et got %0d/%0d expected 8/2", n_lt, n_et);
    end
    $display("test_frame_seq: lt=%0d et=%0d", n_lt, n_et);
  endtask

  task automatic test_length_expiry();
    do_reset();
    wr(2'd1, 8'hF4);
    wr(2'd0, 8'h3E);
    checks++;
    if (oLenCount !== 7'd2) begin errors++; $display("FAIL len_load: got %0d expected 2", oLenCount); end
    wr(2'd3, 8'hC3);
    checks++;
    if ({oTrigger, oActive, oNR24} !== {1'b1, 1'b1, 8'h43}) begin
      errors++;
      $display("FAIL trigger: trig/act/nr24 got %b/%b/%0h expected 1/1/43", oTrigger, oActive, oNR24);
    end
    cyc();
    checks++;
    if (oTrigger !== 1'b0) begin errors++; $display("FAIL trigger_width: got %b expected 0", oTrigger); end
    tick();
    checks++;
    if (oLenCount !== 7'd1) begin errors++; $display("FAIL len_dec1: got %0d expected 1", oLenCount); end
    tick();
    tick();
    checks++;
    if ({oLenCount, oActive} !== {7'd0, 1'b0}) begin
      errors++;
      $display("FAIL len_expire: len/act got %0d/%b expected 0/0", oLenCount, oActive);
    end
    wr(2'd3, 8'h80);
    checks++;
    if ({oLenCount, oActive} !== {7'd64, 1'b1}) begin
      errors++;
      $display("FAIL reload: len/act got %0d/%b expected 64/1", oLenCount, oActive);
    end
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (oLenCount !== 7'd64) begin errors++; $display("FAIL len_hold: got %0d expected 64", oLenCount); end
    wr(2'd1, 8'h07);
    checks++;
    if (oActive !== 1'b0) begin errors++; $display("FAIL dac_off: oActive got %b expected 0", oActive); end
    wr(2'd3, 8'h80);
    checks++;
    if ({oTrigger, oActive} !== 2'b10) begin
      errors++;
      $display("FAIL dac_off_trigger: trig/act got %b/%b expected 1/0", oTrigger, oActive);
    end
    $display("test_length_expiry: len=%0d act=%b", oLenCount, oActive);
  endtask

  task automatic test_back_to_back();
    iWe = 1'b1; iAddr = 2'd0; iData = 8'h10;
    cyc();
    checks++;
    if ({oNR21, oLenCount} !== {8'h10, 7'd48}) begin
      errors++;
      $display("FAIL b2b_nr21: nr21/len got %0h/%0d expected 10/48", oNR21, oLenCount);
    end
    iAddr = 2'd2; iData = 8'h55;
    cyc();
    checks++;
    if (oNR23 !== 8'h55) begin errors++; $display("FAIL b2b_nr23: got %0h expected 55", oNR23); end
    iAddr = 2'd1; iData = 8'hA0;
    cyc();
    iWe = 1'b0;
    checks++;
    if (oNR22 !== 8'hA0) begin errors++; $display("FAIL b2b_nr22: got %0h expected a0", oNR22); end
    $display("test_back_to_back: nr21=%0h nr22=%0h nr23=%0h", oNR21, oNR22, oNR23);
  endtask

  task automatic test_simultaneous();
    wr(2'd3, 8'h40);
    if (model_step % 2 != 0) tick();
    iTick512 = 1'b1;
    cyc();
    iTick512 = 1'b0;
    model_step = (model_step + 1) % 8;
    wr(2'd0, 8'h3C);
    checks++;
    if (oLenCount !== 7'd4) begin errors++; $display("FAIL load_wins: got %0d expected 4", oLenCount); end
    if (model_step % 2 != 0) tick();
    iTick512 = 1'b1;
    cyc();
    iTick512 = 1'b0;
    model_step = (model_step + 1) % 8;
    wr(2'd3, 8'hC0);
    checks++;
    if ({oLenCount, oTrigger, oActive} !== {7'd4, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL trigger_wins: len/trig/act got %0d/%b/%b expected 4/1/1", oLenCount, oTrigger, oActive);
    end
    while (model_step % 2 != 0) tick();
    tick();
    checks++;
    if (oLenCount !== 7'd3) begin errors++; $display("FAIL len_dec_enabled: got %0d expected 3", oLenCount); end
    $display("test_simultaneous: len=%0d", oLenCount);
  endtask

  task automatic test_power_off();
    tick();
    iMasterEn = 1'b0;
    cyc();
    checks++;
    if ({oNR21, oNR22, oNR23, oNR24, oActive, oLenCount} !== 40'd0) begin
      errors++;
      $display("FAIL power_off_clear: got %0h expected 0", {oNR21, oNR22, oNR23, oNR24, oActive, oLenCount});
    end
    wr(2'd0, 8'hFF);
    wr(2'd3, 8'h80);
    checks++;
    if ({oNR21, oNR24, oTrigger, oLenCount} !== 24'd0) begin
      errors++;
      $display("FAIL power_off_write: got %0h expected 0", {oNR21, oNR24, oTrigger, oLenCount});
    end
    tick();
    tick();
    iMasterEn = 1'b1;
    model_step = 0;
    tick();
    tick();
    $display("test_power_off done, checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    #1;
    test_reset();
    test_frame_seq();
    test_length_expiry();
    test_back_to_back();
    test_simultaneous();
    test_power_off();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
